// File: rtl/board_input_ctrl.sv
// Board glue: button conditioning (sync, polarity, debounce, edge pulses), core reset stretcher and LED heartbeat.
// Define BOARD_INPUT_AUTOREPEAT_EN to add per-button press autorepeat (HOLD_BTN excluded).
module board_input_ctrl #(
  parameter int                 NUM_BTN          = 4,
  parameter logic [NUM_BTN-1:0] BTN_ACTIVE_LOW   = 4'b0001,
  parameter int                 DEBOUNCE_CYCLES  = 65536,
  parameter int                 POR_CYCLES       = 16,
  parameter int                 HOLD_BTN         = 0,
  parameter int                 HOLD_CYCLES      = 25200000,
  parameter int                 HEARTBEAT_CYCLES = 25200000
`ifdef BOARD_INPUT_AUTOREPEAT_EN
  ,
  parameter int                 REPEAT_DELAY     = 12600000,
  parameter int                 REPEAT_PERIOD    = 2520000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               sys_rst_n,
  output logic               hold_active,
  output logic               heartbeat
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1)  ? $clog2(DEBOUNCE_CYCLES)  : 1;
  localparam int POR_W  = (POR_CYCLES > 1)       ? $clog2(POR_CYCLES)       : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1)      ? $clog2(HOLD_CYCLES)      : 1;
  localparam int HB_W   = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_CYCLES - 1);

  localparam logic [1:0] ST_POR  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] s;
  logic [NUM_BTN-1:0] level_nxt;
  logic [NUM_BTN-1:0] rpt_pulse;
  logic [DB_W-1:0]    db_cnt     [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_nxt [NUM_BTN];
  logic [1:0]         state;
  logic [POR_W-1:0]   por_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HB_W-1:0]    hb_cnt;

  // Synchronisers reset to the idle pin level so no phantom press appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= BTN_ACTIVE_LOW;
      sync2 <= BTN_ACTIVE_LOW;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ BTN_ACTIVE_LOW;

  always_comb begin
    level_nxt = btn_level;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_nxt[i] = '0;
      if (s[i] != btn_level[i]) begin
        if (db_cnt[i] == DB_LAST) level_nxt[i] = s[i];
        else                      db_cnt_nxt[i] = db_cnt[i] + 1'b1;
      end
    end
  end

  // Pulses are registered alongside btn_level so they coincide with the level edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      btn_level   <= level_nxt;
      btn_press   <= (level_nxt & ~btn_level) | rpt_pulse;
      btn_release <= ~level_nxt & btn_level;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= db_cnt_nxt[i];
    end
  end

`ifdef BOARD_INPUT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]   rpt_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_armed;

  always_comb begin
    rpt_pulse = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_pulse[i] = (i != HOLD_BTN) && btn_level[i] && level_nxt[i] &&
                     (rpt_cnt[i] == (rpt_armed[i] ? RPT_NEXT : RPT_FIRST));
    end
  end

  // rpt_armed switches the terminal count from the first delay to the repeat period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_armed <= '0;
      for (int i = 0; i < NUM_BTN; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!btn_level[i] || !level_nxt[i] || i == HOLD_BTN) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b0;
        end else if (rpt_pulse[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b1;
        end else begin
          rpt_cnt[i]   <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rpt_pulse = '0;
`endif

  // HOLD exits on level_nxt so hold_active drops in the same cycle btn_level falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_POR;
      por_cnt     <= '0;
      hold_cnt    <= '0;
      sys_rst_n   <= 1'b0;
      hold_active <= 1'b0;
    end else begin
      case (state)
        ST_POR: begin
          hold_cnt <= '0;
          if (por_cnt == POR_LAST) begin
            state     <= ST_RUN;
            por_cnt   <= '0;
            sys_rst_n <= 1'b1;
          end else begin
            por_cnt <= por_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (btn_level[HOLD_BTN]) begin
            if (hold_cnt == HOLD_LAST) begin
              state       <= ST_HOLD;
              hold_cnt    <= '0;
              sys_rst_n   <= 1'b0;
              hold_active <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else begin
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (!level_nxt[HOLD_BTN]) begin
            state       <= ST_POR;
            hold_active <= 1'b0;
            por_cnt     <= '0;
          end
        end
        default: begin
          state       <= ST_POR;
          por_cnt     <= '0;
          sys_rst_n   <= 1'b0;
          hold_active <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt    <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_board_input_ctrl.sv
// Directed bench for board_input_ctrl: vector table for debounce/hold-reset plus hand sequences for reset and heartbeat.
module tb_board_input_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       sys_rst_n;
  logic       hold_active;
  logic       heartbeat;

  int total;
  int bad;

  board_input_ctrl #(
    .NUM_BTN         (4),
    .BTN_ACTIVE_LOW  (4'b0001),
    .DEBOUNCE_CYCLES (4),
    .POR_CYCLES      (8),
    .HOLD_BTN        (0),
    .HOLD_CYCLES     (20),
    .HEARTBEAT_CYCLES(10)
`ifdef BOARD_INPUT_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (30),
    .REPEAT_PERIOD   (10)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sys_rst_n  (sys_rst_n),
    .hold_active(hold_active),
    .heartbeat  (heartbeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] raw;
    int         cycles;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic       rst;
    logic       hold;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] raw, input int cycles);
    btn_raw = raw;
    repeat (cycles) step();
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    // raw, cycles, level, press, release, sys_rst_n, hold_active
    vecs[0]  = '{4'b0011,  3, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[1]  = '{4'b0001,  8, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{4'b0011,  5, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[3]  = '{4'b0011,  1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0};
    vecs[4]  = '{4'b0011,  1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{4'b0011,  3, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[6]  = '{4'b0001,  5, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[7]  = '{4'b0001,  1, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0};
    vecs[8]  = '{4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[9]  = '{4'b0000,  5, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[10] = '{4'b0000,  1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[11] = '{4'b0000, 19, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[12] = '{4'b0000,  1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[13] = '{4'b0000, 14, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[14] = '{4'b0001,  5, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[15] = '{4'b0001,  1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0};
    vecs[16] = '{4'b0001,  7, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[17] = '{4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[18] = '{4'b0000,  6, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[19] = '{4'b0000, 12, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[20] = '{4'b0001,  6, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0};
    vecs[21] = '{4'b0000,  6, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[22] = '{4'b0000, 19, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[23] = '{4'b0000,  1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[24] = '{4'b1110,  6, 4'b1111, 4'b1110, 4'b0000, 1'b0, 1'b1};

    rst_n   = 1'b0;
    btn_raw = 4'b0001;
    step();
    step();
    checkOutput("rst.level",   btn_level,         4'b0000);
    checkOutput("rst.press",   btn_press,         4'b0000);
    checkOutput("rst.release", btn_release,       4'b0000);
    checkOutput("rst.sys_rst", {3'b0, sys_rst_n}, 4'b0000);
    checkOutput("rst.hold",    {3'b0, hold_active}, 4'b0000);
    checkOutput("rst.hb",      {3'b0, heartbeat}, 4'b0000);

    // Power-up: reset stretch of 8 cycles, heartbeat toggling every 10 cycles.
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      checkOutput($sformatf("por.sys_rst@%0d", k), {3'b0, sys_rst_n}, {3'b0, (k >= 8)});
      checkOutput($sformatf("por.hb@%0d", k), {3'b0, heartbeat},
                  {3'b0, ((k >= 10 && k < 20) || k >= 30)});
      checkOutput($sformatf("por.level@%0d", k), btn_level, 4'b0000);
    end

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].raw, vecs[i].cycles);
      checkOutput($sformatf("v%0d.level", i),   btn_level,   vecs[i].level);
      checkOutput($sformatf("v%0d.press", i),   btn_press,   vecs[i].press);
      checkOutput($sformatf("v%0d.release", i), btn_release, vecs[i].rel);
      checkOutput($sformatf("v%0d.sys_rst", i), {3'b0, sys_rst_n},   {3'b0, vecs[i].rst});
      checkOutput($sformatf("v%0d.hold", i),    {3'b0, hold_active}, {3'b0, vecs[i].hold});
    end

    // Mid-operation reset while HOLD is latched with every button pressed.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.level",   btn_level,           4'b0000);
    checkOutput("midrst.press",   btn_press,           4'b0000);
    checkOutput("midrst.release", btn_release,         4'b0000);
    checkOutput("midrst.sys_rst", {3'b0, sys_rst_n},   4'b0000);
    checkOutput("midrst.hold",    {3'b0, hold_active}, 4'b0000);
    checkOutput("midrst.hb",      {3'b0, heartbeat},   4'b0000);
    btn_raw = 4'b0001;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput($sformatf("rerun.sys_rst@%0d", k), {3'b0, sys_rst_n}, {3'b0, (k >= 8)});
      checkOutput($sformatf("rerun.hold@%0d", k), {3'b0, hold_active}, 4'b0000);
      checkOutput($sformatf("rerun.level@%0d", k), btn_level, 4'b0000);
    end

    // Long press of button 2: one press pulse without autorepeat, repeats at +30/+40/+50 with it.
    applyStimulus(4'b0101, 6);
    checkOutput("rpt.first_press", btn_press, 4'b0100);
    for (int k = 1; k <= 60; k++) begin
      step();
`ifdef BOARD_INPUT_AUTOREPEAT_EN
      checkOutput($sformatf("rpt.press@%0d", k), btn_press,
                  ((k == 30 || k == 40 || k == 50) ? 4'b0100 : 4'b0000));
`else
      checkOutput($sformatf("rpt.press@%0d", k), btn_press, 4'b0000);
`endif
    end
    applyStimulus(4'b0001, 6);
    checkOutput("rpt.release", btn_release, 4'b0100);

    // The hold button never autorepeats.
    applyStimulus(4'b0000, 6);
    checkOutput("rpt0.first_press", btn_press, 4'b0001);
    for (int k = 1; k <= 40; k++) begin
      step();
      checkOutput($sformatf("rpt0.press@%0d", k), btn_press, 4'b0000);
    end
    applyStimulus(4'b0001, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
